// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack bus between the fetch stage and imem.
// Single outstanding request; Addr held until Ack.
interface fetch_unit_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Rdata;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ack,
    input  IMem_Rdata
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ack,
    output IMem_Rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns fetch PC, single-outstanding imem handshake.
// Optional perf counters under `FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  fetch_unit_if.master imem,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] Perf_Instr_Cnt,
  output logic [31:0] Perf_Bubble_Cnt,
`endif
  output logic        Fetch_Valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BUB = 32'h2A2A_2A2A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        valid_q;
  logic [31:0] slot_ins_q;
  logic [31:0] slot_pc_q;
  logic [31:0] skid_q;

  logic        consume;
  logic        ack;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign consume = valid_q & ~Stall_En & ~Redirect_En;
  assign ack     = imem.IMem_Ack;
  assign tgt     = Redirect_PC & ~32'h3;
  assign pc_inc  = pc_q + 32'd4;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      slot_ins_q <= '0;
      slot_pc_q  <= '0;
      skid_q     <= '0;
    end else if (Redirect_En) begin
      valid_q <= 1'b0;
      skid_q  <= '0;
      pc_q    <= tgt;
      unique case (state_q)
        S_IDLE, S_HOLD: begin
          state_q <= S_REQ;
          addr_q  <= tgt;
        end
        S_REQ, S_DROP: begin
          // an issued request is never withdrawn
          if (ack) begin
            state_q <= S_REQ;
            addr_q  <= tgt;
          end else begin
            state_q <= S_DROP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end else begin
      if (consume) valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          addr_q  <= pc_q;
        end
        S_REQ: begin
          if (ack) begin
            if (!valid_q || consume) begin
              slot_ins_q <= imem.IMem_Rdata;
              slot_pc_q  <= pc_q;
              valid_q    <= 1'b1;
              pc_q       <= pc_inc;
              addr_q     <= pc_inc;
            end else begin
              skid_q  <= imem.IMem_Rdata;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // pc_q still names the skid word
          if (consume) begin
            slot_ins_q <= skid_q;
            slot_pc_q  <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_inc;
            addr_q     <= pc_inc;
            state_q    <= S_REQ;
          end
        end
        S_DROP: begin
          if (ack) begin
            addr_q  <= pc_q;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.IMem_Req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem.IMem_Addr = addr_q;
  assign Fetch_Valid    = valid_q;

  always_comb begin
    Instr_F     = '0;
    PC_F        = '0;
    PC_Plus_4_F = '0;
    if (valid_q) begin
      Instr_F     = slot_ins_q;
      PC_F        = slot_pc_q;
      PC_Plus_4_F = slot_pc_q + 32'd4;
    end else if (state_q != S_IDLE) begin
      Instr_F     = NOP;
      PC_F        = BUB;
      PC_Plus_4_F = BUB;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] icnt_q;
  logic [31:0] bcnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      icnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      if (consume && icnt_q != '1)
        icnt_q <= icnt_q + 32'd1;
      if (!Stall_En && !valid_q && bcnt_q != '1)
        bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign Perf_Instr_Cnt  = icnt_q;
  assign Perf_Bubble_Cnt = bcnt_q;
`endif

endmodule
